// File: rtl/pci_arbiter_param.sv
// Parametrised central PCI arbiter: fixed-priority or round-robin selection, optional
// bus parking, grant timeout for idle owners and a one-clock all-idle handoff gap.
module pci_arbiter_param #(
  parameter int N_MASTERS   = 3,
  parameter int RR_MODE     = 0,
  parameter int PARK_EN     = 0,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MASTERS-1:0]         req_n,
  input  logic                         frame_n,
  input  logic                         irdy_n,
  output logic [N_MASTERS-1:0]         gnt_n,
  output logic [$clog2(N_MASTERS)-1:0] owner,
  output logic                         bus_busy,
  output logic                         timeout_evt
);

  localparam int OW = $clog2(N_MASTERS);
  localparam logic [7:0] TO_LIM = 8'(GNT_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANTED,
    S_BUSY,
    S_HANDOFF,
    S_WAIT      // new grant held while the previous transaction drains
  } state_t;

  state_t               state_q, state_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        ptr_q, ptr_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 tevt_q, tevt_d;

  logic                 bus_idle;
  logic                 any_req;
  logic                 other_req;
  logic                 owner_req;
  logic [OW-1:0]        winner;
  logic [OW-1:0]        cand;
  logic                 found;
  logic [OW-1:0]        next_owner;

  function automatic logic [N_MASTERS-1:0] grant_of(input logic [OW-1:0] idx);
    return ~(N_MASTERS'(1) << idx);
  endfunction

  assign bus_idle   = frame_n & irdy_n;
  assign any_req    = ~&req_n;
  assign owner_req  = ~req_n[owner_q];
  assign other_req  = |(~req_n & ~(N_MASTERS'(1) << owner_q));
  assign next_owner = (owner_q == OW'(N_MASTERS - 1)) ? '0 : owner_q + 1'b1;

  // Scan starts at the RR pointer (or index 0 in fixed mode); first requester wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      cand = (RR_MODE != 0) ? OW'((int'(ptr_q) + i) % N_MASTERS) : OW'(i);
      if (!found && !req_n[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q && !bus_idle;
    tevt_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          // Parked on someone else: open the one-clock gap before switching.
          if (~&gnt_q && winner != owner_q) begin
            gnt_d   = '1;
            state_d = S_HANDOFF;
          end else begin
            gnt_d   = grant_of(winner);
            owner_d = winner;
            cnt_d   = '0;
            state_d = S_GRANTED;
          end
        end
      end

      S_GRANTED: begin
        if (!frame_n) begin
          busy_d  = 1'b1;
          cnt_d   = '0;
          ptr_d   = next_owner;
          state_d = S_BUSY;
        end else if (!owner_req) begin
          if (PARK_EN == 0) gnt_d = '1;
          state_d = S_IDLE;
        end else if (bus_idle) begin
          if (cnt_q + 8'd1 == TO_LIM) begin
            gnt_d   = '1;
            tevt_d  = 1'b1;
            cnt_d   = '0;
            if (RR_MODE != 0) ptr_d = next_owner;
            state_d = S_HANDOFF;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      S_BUSY: begin
        if (other_req && (!owner_req || RR_MODE != 0)) begin
          gnt_d   = '1;
          state_d = S_HANDOFF;
        end else if (bus_idle) begin
          if (owner_req) begin
            cnt_d   = '0;
            state_d = S_GRANTED;
          end else begin
            if (PARK_EN == 0) gnt_d = '1;
            state_d = S_IDLE;
          end
        end
      end

      S_HANDOFF: begin
        if (any_req) begin
          gnt_d   = grant_of(winner);
          owner_d = winner;
          cnt_d   = '0;
          state_d = bus_idle ? S_GRANTED : S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WAIT: begin
        if (bus_idle) begin
          cnt_d   = '0;
          state_d = S_GRANTED;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '1;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      tevt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      tevt_q  <= tevt_d;
    end
  end

  assign gnt_n       = gnt_q;
  assign owner       = owner_q;
  assign bus_busy    = busy_q;
  assign timeout_evt = tevt_q;

endmodule

// File: tb/tb_pci_arbiter_param.sv
// Directed bench for pci_arbiter_param: five instances, one per parameter set,
// each exercised by hand-computed vectors.
module tb_pci_arbiter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic mon_en = 1'b0;

  logic rst, rr_rst;

  // Fixed priority, N=3
  logic [2:0] f_req;
  logic f_frame, f_irdy, f_busy, f_tevt;
  logic [2:0] f_gnt;
  logic [1:0] f_own;
  // Round robin, N=4
  logic [3:0] r_req;
  logic r_frame, r_irdy, r_busy, r_tevt;
  logic [3:0] r_gnt;
  logic [1:0] r_own;
  // Round robin, timeout 4
  logic [2:0] t_req;
  logic t_frame, t_irdy, t_busy, t_tevt;
  logic [2:0] t_gnt;
  logic [1:0] t_own;
  // Parking
  logic [2:0] p_req;
  logic p_frame, p_irdy, p_busy, p_tevt;
  logic [2:0] p_gnt;
  logic [1:0] p_own;
  // Hidden arbitration, timeout 4
  logic [2:0] h_req;
  logic h_frame, h_irdy, h_busy, h_tevt;
  logic [2:0] h_gnt;
  logic [1:0] h_own;

  pci_arbiter_param #(.N_MASTERS(3), .RR_MODE(0), .PARK_EN(0), .GNT_TIMEOUT(16)) u_fp (
    .clk(clk), .rst(rst), .req_n(f_req), .frame_n(f_frame), .irdy_n(f_irdy),
    .gnt_n(f_gnt), .owner(f_own), .bus_busy(f_busy), .timeout_evt(f_tevt));

  pci_arbiter_param #(.N_MASTERS(4), .RR_MODE(1), .PARK_EN(0), .GNT_TIMEOUT(16)) u_rr (
    .clk(clk), .rst(rr_rst), .req_n(r_req), .frame_n(r_frame), .irdy_n(r_irdy),
    .gnt_n(r_gnt), .owner(r_own), .bus_busy(r_busy), .timeout_evt(r_tevt));

  pci_arbiter_param #(.N_MASTERS(3), .RR_MODE(1), .PARK_EN(0), .GNT_TIMEOUT(4)) u_to (
    .clk(clk), .rst(rst), .req_n(t_req), .frame_n(t_frame), .irdy_n(t_irdy),
    .gnt_n(t_gnt), .owner(t_own), .bus_busy(t_busy), .timeout_evt(t_tevt));

  pci_arbiter_param #(.N_MASTERS(3), .RR_MODE(0), .PARK_EN(1), .GNT_TIMEOUT(16)) u_pk (
    .clk(clk), .rst(rst), .req_n(p_req), .frame_n(p_frame), .irdy_n(p_irdy),
    .gnt_n(p_gnt), .owner(p_own), .bus_busy(p_busy), .timeout_evt(p_tevt));

  pci_arbiter_param #(.N_MASTERS(3), .RR_MODE(0), .PARK_EN(0), .GNT_TIMEOUT(4)) u_hd (
    .clk(clk), .rst(rst), .req_n(h_req), .frame_n(h_frame), .irdy_n(h_irdy),
    .gnt_n(h_gnt), .owner(h_own), .bus_busy(h_busy), .timeout_evt(h_tevt));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // At most one grant low in any cycle, on every instance.
  always @(negedge clk) begin
    if (mon_en) begin
      check("onehot_fp", 32'($countones(~f_gnt) <= 1), 32'd1);
      check("onehot_rr", 32'($countones(~r_gnt) <= 1), 32'd1);
      check("onehot_to", 32'($countones(~t_gnt) <= 1), 32'd1);
      check("onehot_pk", 32'($countones(~p_gnt) <= 1), 32'd1);
      check("onehot_hd", 32'($countones(~h_gnt) <= 1), 32'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rr_exp [4];
    logic [1:0] rr_own [4];
    rr_exp = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rr_own = '{2'd1, 2'd2, 2'd3, 2'd0};

    rst = 1'b1; rr_rst = 1'b1;
    f_req = '1; f_frame = 1'b1; f_irdy = 1'b1;
    r_req = '1; r_frame = 1'b1; r_irdy = 1'b1;
    t_req = '1; t_frame = 1'b1; t_irdy = 1'b1;
    p_req = '1; p_frame = 1'b1; p_irdy = 1'b1;
    h_req = '1; h_frame = 1'b1; h_irdy = 1'b1;
    tick(); tick();
    check("rst_fp_gnt", 32'(f_gnt), 32'h7);
    check("rst_fp_own", 32'(f_own), 32'h0);
    check("rst_fp_busy", 32'(f_busy), 32'h0);
    check("rst_fp_tevt", 32'(f_tevt), 32'h0);
    check("rst_rr_gnt", 32'(r_gnt), 32'hf);
    rst = 1'b0; rr_rst = 1'b0;
    mon_en = 1'b1;
    tick();
    check("idle_fp_gnt", 32'(f_gnt), 32'h7);

    // Fixed priority: all request, index 0 keeps the bus across 2-clock frames.
    f_req = 3'b000;
    tick();
    check("fp_first", 32'(f_gnt), 32'h6);
    check("fp_own", 32'(f_own), 32'h0);
    for (int k = 0; k < 3; k++) begin
      f_frame = 1'b0;
      tick();
      check("fp_busy1_gnt", 32'(f_gnt), 32'h6);
      check("fp_busy1", 32'(f_busy), 32'h1);
      tick();
      check("fp_busy2_gnt", 32'(f_gnt), 32'h6);
      f_frame = 1'b1;
      tick();
      check("fp_idle_gnt", 32'(f_gnt), 32'h6);
      check("fp_idle_busy", 32'(f_busy), 32'h0);
    end
    f_req = 3'b111;
    tick();
    check("fp_release", 32'(f_gnt), 32'h7);

    // Round robin: grants rotate with one all-ones gap per switch.
    r_req = 4'b0000;
    tick();
    check("rr_first", 32'(r_gnt), 32'he);
    for (int k = 0; k < 4; k++) begin
      r_frame = 1'b0;
      tick();
      check("rr_busy", 32'(r_busy), 32'h1);
      r_frame = 1'b1;
      tick();
      check("rr_gap", 32'(r_gnt), 32'hf);
      tick();
      check("rr_gnt", 32'(r_gnt), 32'(rr_exp[k]));
      check("rr_own", 32'(r_own), 32'(rr_own[k]));
    end

    // Reset mid-transaction with master 1 owning the bus.
    r_frame = 1'b0; tick();
    r_frame = 1'b1; tick();
    tick();
    check("rr_pre_rst_gnt", 32'(r_gnt), 32'hd);
    r_frame = 1'b0;
    tick();
    check("rr_pre_rst_busy", 32'(r_busy), 32'h1);
    rr_rst = 1'b1;
    tick();
    check("rr_rst_gnt", 32'(r_gnt), 32'hf);
    check("rr_rst_own", 32'(r_own), 32'h0);
    check("rr_rst_busy", 32'(r_busy), 32'h0);
    rr_rst = 1'b0; r_frame = 1'b1;
    tick();
    check("rr_restart", 32'(r_gnt), 32'he);
    r_req = 4'b1111;

    // Timeout: master 1 granted but never starts; masters 1 and 2 request.
    t_req = 3'b001;
    tick();
    check("to_grant", 32'(t_gnt), 32'h5);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("to_hold", 32'(t_gnt), 32'h5);
      check("to_no_evt", 32'(t_tevt), 32'h0);
    end
    tick();
    check("to_revoke", 32'(t_gnt), 32'h7);
    check("to_evt", 32'(t_tevt), 32'h1);
    tick();
    check("to_next", 32'(t_gnt), 32'h3);
    check("to_next_own", 32'(t_own), 32'h2);
    check("to_evt_pulse", 32'(t_tevt), 32'h0);
    t_req = 3'b111;
    tick();
    check("to_release", 32'(t_gnt), 32'h7);

    // Parking on master 2, then master 0 takes over after one gap cycle.
    p_req = 3'b011;
    tick();
    check("pk_grant", 32'(p_gnt), 32'h3);
    p_frame = 1'b0;
    tick();
    p_frame = 1'b1; p_req = 3'b111;
    tick();
    check("pk_parked", 32'(p_gnt), 32'h3);
    repeat (20) tick();
    check("pk_still", 32'(p_gnt), 32'h3);
    check("pk_own", 32'(p_own), 32'h2);
    check("pk_no_evt", 32'(p_tevt), 32'h0);
    p_req = 3'b110;
    tick();
    check("pk_gap", 32'(p_gnt), 32'h7);
    tick();
    check("pk_new", 32'(p_gnt), 32'h6);
    check("pk_new_own", 32'(p_own), 32'h0);

    // Hidden arbitration: master 1 granted during master 0's transaction.
    h_req = 3'b110;
    tick();
    check("hd_grant0", 32'(h_gnt), 32'h6);
    h_frame = 1'b0;
    tick();
    check("hd_busy", 32'(h_busy), 32'h1);
    h_req = 3'b101;
    tick();
    check("hd_drop0", 32'(h_gnt), 32'h7);
    check("hd_drop0_busy", 32'(h_busy), 32'h1);
    tick();
    check("hd_grant1", 32'(h_gnt), 32'h5);
    check("hd_grant1_own", 32'(h_own), 32'h1);
    repeat (6) begin
      tick();
      check("hd_wait_gnt", 32'(h_gnt), 32'h5);
      check("hd_wait_evt", 32'(h_tevt), 32'h0);
      check("hd_wait_busy", 32'(h_busy), 32'h1);
    end
    h_frame = 1'b1;
    tick();
    check("hd_granted_busy", 32'(h_busy), 32'h0);
    repeat (3) begin
      tick();
      check("hd_cnt_gnt", 32'(h_gnt), 32'h5);
      check("hd_cnt_evt", 32'(h_tevt), 32'h0);
    end
    tick();
    check("hd_timeout_gnt", 32'(h_gnt), 32'h7);
    check("hd_timeout_evt", 32'(h_tevt), 32'h1);
    h_req = 3'b111;
    tick();
    check("hd_idle", 32'(h_gnt), 32'h7);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
